// File: rtl/bignum_pkg.sv
// Shared definitions for the bignum divider datapath: default block sizing
// and the job arbiter state encoding.
package bignum_pkg;

    localparam int DEF_REGISTER_SIZE = 32;
    localparam int DEF_NUM_BLOCKS_IN = 128;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_FEEDING  = 2'd1,
        ARB_DRAINING = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick. With both requesting, the requester that
// was not served last wins. Purely combinational; the caller registers it.
module rr_arbiter_2 (
    input  logic [1:0] req_in,
    input  logic       last_served_in,
    output logic [1:0] grant_out
);

    // Single requests win outright; ties go to the one not served last.
    always_comb begin
        grant_out = 2'b00;
        case (req_in)
            2'b01:   grant_out = 2'b01;
            2'b10:   grant_out = 2'b10;
            2'b11:   grant_out = last_served_in ? 2'b01 : 2'b10;
            default: grant_out = 2'b00;
        endcase
    end

endmodule

// File: rtl/divider_job_arbiter.sv
// Shares one block-serial divider between two requesters. A job feeds
// NUM_BLOCKS_IN dividend blocks from the owner, then drains NUM_BLOCKS_IN/2
// remainder/quotient block pairs back to the owner before releasing.
module divider_job_arbiter
    import bignum_pkg::*;
#(
    parameter int REGISTER_SIZE = DEF_REGISTER_SIZE,
    parameter int NUM_BLOCKS_IN = DEF_NUM_BLOCKS_IN
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [1:0]               req_in,
    output logic [1:0]               grant_out,
    input  logic [1:0]               valid_in,
    input  logic [REGISTER_SIZE-1:0] block_a0_in,
    input  logic [REGISTER_SIZE-1:0] block_a1_in,
    output logic                     div_rst_out,
    output logic                     div_valid_out,
    output logic [REGISTER_SIZE-1:0] div_block_out,
    input  logic                     div_valid_in,
    input  logic [REGISTER_SIZE-1:0] div_r_block_in,
    input  logic [REGISTER_SIZE-1:0] div_q_block_in,
    output logic [1:0]               result_valid_out,
    output logic [REGISTER_SIZE-1:0] r_block_out,
    output logic [REGISTER_SIZE-1:0] q_block_out,
    output logic [1:0]               done_out,
    output logic                     error_out
);

    localparam int NUM_BLOCKS_OUT = NUM_BLOCKS_IN / 2;
    localparam int IN_W  = (NUM_BLOCKS_IN  > 1) ? $clog2(NUM_BLOCKS_IN)  : 1;
    localparam int OUT_W = (NUM_BLOCKS_OUT > 1) ? $clog2(NUM_BLOCKS_OUT) : 1;
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(NUM_BLOCKS_IN - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(NUM_BLOCKS_OUT - 1);

    arb_state_t              state;
    logic                    owner;
    logic                    last_served;
    logic [IN_W-1:0]         in_count;
    logic [OUT_W-1:0]        out_count;
    logic                    div_rst_q;
    logic [1:0]              pick;
    logic [1:0]              owner_oh;
    logic                    owner_valid;
    logic [REGISTER_SIZE-1:0] owner_block;

    rr_arbiter_2 u_rr (
        .req_in         (req_in),
        .last_served_in (last_served),
        .grant_out      (pick)
    );

    assign owner_oh    = owner ? 2'b10 : 2'b01;
    assign owner_valid = owner ? valid_in[1] : valid_in[0];
    assign owner_block = owner ? block_a1_in : block_a0_in;

    // The divider is held in reset for the whole of rst_in and one cycle
    // after, plus the one-cycle pulse that starts each job.
    assign div_rst_out = rst_in | div_rst_q;

    // Job FSM: arbitrate in IDLE, stream owner blocks in FEEDING, route
    // results back in DRAINING; pulses default low every cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= ARB_IDLE;
            owner            <= 1'b0;
            last_served      <= 1'b1;
            in_count         <= '0;
            out_count        <= '0;
            div_rst_q        <= 1'b1;
            grant_out        <= 2'b00;
            div_valid_out    <= 1'b0;
            div_block_out    <= '0;
            result_valid_out <= 2'b00;
            r_block_out      <= '0;
            q_block_out      <= '0;
            done_out         <= 2'b00;
            error_out        <= 1'b0;
        end else begin
            div_rst_q        <= 1'b0;
            div_valid_out    <= 1'b0;
            result_valid_out <= 2'b00;
            done_out         <= 2'b00;

            case (state)
                ARB_IDLE: begin
                    if (pick != 2'b00) begin
                        state     <= ARB_FEEDING;
                        owner     <= pick[1];
                        grant_out <= pick;
                        div_rst_q <= 1'b1;
                        in_count  <= '0;
                    end
                end
                ARB_FEEDING: begin
                    if (owner_valid) begin
                        div_valid_out <= 1'b1;
                        div_block_out <= owner_block;
                        if (in_count == IN_LAST) begin
                            state     <= ARB_DRAINING;
                            out_count <= '0;
                        end else begin
                            in_count <= in_count + 1'b1;
                        end
                    end
                end
                ARB_DRAINING: begin
                    // Dividend blocks after the last one are a protocol slip.
                    if (owner_valid)
                        error_out <= 1'b1;
                    if (div_valid_in) begin
                        result_valid_out <= owner_oh;
                        r_block_out      <= div_r_block_in;
                        q_block_out      <= div_q_block_in;
                        if (out_count == OUT_LAST) begin
                            state       <= ARB_IDLE;
                            grant_out   <= 2'b00;
                            done_out    <= owner_oh;
                            last_served <= owner;
                        end else begin
                            out_count <= out_count + 1'b1;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase

            // Divider results are only meaningful while draining.
            if (div_valid_in && state != ARB_DRAINING)
                error_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_divider_job_arbiter.sv
// Directed bench for divider_job_arbiter with 4 blocks of 8 bits per job.
module tb_divider_job_arbiter;

    localparam int RS = 8;
    localparam int NB = 4;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [1:0]    req_in;
    logic [1:0]    grant_out;
    logic [1:0]    valid_in;
    logic [RS-1:0] block_a0_in;
    logic [RS-1:0] block_a1_in;
    logic          div_rst_out;
    logic          div_valid_out;
    logic [RS-1:0] div_block_out;
    logic          div_valid_in;
    logic [RS-1:0] div_r_block_in;
    logic [RS-1:0] div_q_block_in;
    logic [1:0]    result_valid_out;
    logic [RS-1:0] r_block_out;
    logic [RS-1:0] q_block_out;
    logic [1:0]    done_out;
    logic          error_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [RS-1:0] rv [2];
    logic [RS-1:0] qv [2];

    divider_job_arbiter #(.REGISTER_SIZE(RS), .NUM_BLOCKS_IN(NB)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_in           (req_in),
        .grant_out        (grant_out),
        .valid_in         (valid_in),
        .block_a0_in      (block_a0_in),
        .block_a1_in      (block_a1_in),
        .div_rst_out      (div_rst_out),
        .div_valid_out    (div_valid_out),
        .div_block_out    (div_block_out),
        .div_valid_in     (div_valid_in),
        .div_r_block_in   (div_r_block_in),
        .div_q_block_in   (div_q_block_in),
        .result_valid_out (result_valid_out),
        .r_block_out      (r_block_out),
        .q_block_out      (q_block_out),
        .done_out         (done_out),
        .error_out        (error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_reset_state();
        chk("rst grant", 32'(grant_out), 0);
        chk("rst div_valid", 32'(div_valid_out), 0);
        chk("rst div_block", 32'(div_block_out), 0);
        chk("rst result_valid", 32'(result_valid_out), 0);
        chk("rst r_block", 32'(r_block_out), 0);
        chk("rst q_block", 32'(q_block_out), 0);
        chk("rst done", 32'(done_out), 0);
        chk("rst error", 32'(error_out), 0);
        chk("rst div_rst", 32'(div_rst_out), 1);
    endtask

    // Called in the first granted cycle. Feeds NB blocks from requester r,
    // optionally with the other requester spraying FF, then drains 2 results.
    task automatic do_job(input int r, input logic [RS-1:0] base, input bit noise);
        logic [1:0]    oh;
        logic [RS-1:0] blk;
        oh = (r == 0) ? 2'b01 : 2'b10;
        chk("job grant", 32'(grant_out), 32'(oh));
        chk("job div_rst pulse", 32'(div_rst_out), 1);
        for (int k = 0; k < NB; k++) begin
            blk = RS'(base + k * 8'h11);
            valid_in = noise ? 2'b11 : oh;
            if (r == 0) begin
                block_a0_in = blk;
                block_a1_in = noise ? 8'hFF : 8'h00;
            end else begin
                block_a1_in = blk;
                block_a0_in = noise ? 8'hFF : 8'h00;
            end
            tick();
            chk("feed div_valid", 32'(div_valid_out), 1);
            chk("feed div_block", 32'(div_block_out), 32'(blk));
            if (k == 0)
                chk("div_rst one cycle", 32'(div_rst_out), 0);
        end
        valid_in    = 2'b00;
        block_a0_in = '0;
        block_a1_in = '0;
        for (int j = 0; j < 2; j++) begin
            div_valid_in   = 1'b1;
            div_r_block_in = rv[j];
            div_q_block_in = qv[j];
            tick();
            chk("drain result_valid", 32'(result_valid_out), 32'(oh));
            chk("drain r_block", 32'(r_block_out), 32'(rv[j]));
            chk("drain q_block", 32'(q_block_out), 32'(qv[j]));
            chk("drain done", 32'(done_out), (j == 1) ? 32'(oh) : 0);
            chk("drain grant", 32'(grant_out), (j == 1) ? 0 : 32'(oh));
        end
        div_valid_in = 1'b0;
        chk("job error", 32'(error_out), 0);
    endtask

    initial begin
        rv[0] = 8'hA1; rv[1] = 8'hA2;
        qv[0] = 8'hB1; qv[1] = 8'hB2;
        rst_in = 1'b1;
        req_in = 2'b00;
        valid_in = 2'b00;
        block_a0_in = '0;
        block_a1_in = '0;
        div_valid_in = 1'b0;
        div_r_block_in = '0;
        div_q_block_in = '0;
        tick();
        tick();
        chk_reset_state();

        // Single job for requester 0 with blocks 11..44.
        rst_in = 1'b0;
        req_in = 2'b01;
        tick();
        req_in = 2'b00;
        do_job(0, 8'h11, 1'b0);
        tick();
        chk("post-job done clear", 32'(done_out), 0);
        chk("post-job result clear", 32'(result_valid_out), 0);
        chk("post-job grant idle", 32'(grant_out), 0);

        // Fresh reset so the contention test starts from last_served = 1.
        rst_in = 1'b1;
        tick();
        chk_reset_state();
        rst_in = 1'b0;
        req_in = 2'b11;
        tick();
        do_job(0, 8'h05, 1'b1);
        tick();
        do_job(1, 8'h20, 1'b0);
        tick();
        do_job(0, 8'h30, 1'b0);
        req_in = 2'b00;
        tick();
        chk("contention idle grant", 32'(grant_out), 0);

        // Requester 1 drops its request right after the grant.
        req_in = 2'b10;
        tick();
        req_in = 2'b00;
        do_job(1, 8'h40, 1'b0);

        // Stray divider result while feeding, then reset after 2nd block.
        req_in = 2'b01;
        tick();
        req_in = 2'b00;
        chk("stray grant", 32'(grant_out), 2'b01);
        valid_in = 2'b01;
        block_a0_in = 8'h5A;
        tick();
        block_a0_in = 8'h6B;
        div_valid_in = 1'b1;
        div_r_block_in = 8'hEE;
        div_q_block_in = 8'hDD;
        tick();
        div_valid_in = 1'b0;
        valid_in = 2'b00;
        chk("stray error set", 32'(error_out), 1);
        chk("stray result_valid", 32'(result_valid_out), 0);
        chk("2nd fed block", 32'(div_block_out), 8'h6B);
        tick();
        chk("stray error sticky", 32'(error_out), 1);
        chk("stray result still 0", 32'(result_valid_out), 0);
        rst_in = 1'b1;
        tick();
        chk_reset_state();
        rst_in = 1'b0;
        req_in = 2'b11;
        tick();
        req_in = 2'b00;
        do_job(0, 8'h70, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
